// File: rtl/repl_pkg.sv
// Shared types and constants for the cache replacement victim generator.
package repl_pkg;

    typedef enum logic [1:0] {
        REPL_FIFO,
        REPL_LRU,
        REPL_RANDOM
    } repl_policy_t;

    localparam logic [15:0] LFSR_SEED = 16'h0001;
    // Taps 16,15,13,4 expressed as state-bit positions 15,14,12,3.
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    // Index of the lowest set bit, or 16 when no bit is set.
    function automatic logic [4:0] lowest_set(input logic [15:0] v);
        logic [4:0] idx;
        idx = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/repl_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with the shared seed on reset.
module repl_lfsr
    import repl_pkg::*;
#(
    parameter int unsigned OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/repl_set_gen.sv
// Victim-way generator for a set-associative cache: per-set LRU ages, FIFO pointers or an LFSR.
// Invalid ways always win, and a same-cycle access to the queried set is forwarded.
module repl_set_gen
    import repl_pkg::*;
#(
    parameter int unsigned  SET_ASSOC = 4,
    parameter int unsigned  SET_NUM   = 64,
    parameter repl_policy_t POLICY    = REPL_LRU
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         query_valid,
    input  logic [$clog2(SET_NUM)-1:0]   query_set,
    input  logic [SET_ASSOC-1:0]         line_valid,
    input  logic                         access_valid,
    input  logic [$clog2(SET_NUM)-1:0]   access_set,
    input  logic [SET_ASSOC-1:0]         access_way,
    input  logic                         access_fill,
    output logic                         repl_valid,
    output logic [$clog2(SET_ASSOC)-1:0] repl_way
);

    localparam int unsigned WW = $clog2(SET_ASSOC);

    logic [15:0]   acc_ext;
    logic [15:0]   inv_ext;
    logic [4:0]    acc_idx;
    logic [4:0]    inv_idx;
    logic [WW-1:0] acc_way;
    logic [WW-1:0] inv_way;
    logic [WW-1:0] pol_way;
    logic [WW-1:0] victim;
    logic          acc_en;
    logic          same_set;
    logic          valid_q;
    logic [WW-1:0] way_q;

    always_comb begin
        acc_ext = '0;
        acc_ext[SET_ASSOC-1:0] = access_way;
        inv_ext = '0;
        inv_ext[SET_ASSOC-1:0] = ~line_valid;
        acc_idx  = lowest_set(acc_ext);
        inv_idx  = lowest_set(inv_ext);
        acc_way  = acc_idx[WW-1:0];
        inv_way  = inv_idx[WW-1:0];
        acc_en   = access_valid && (|access_way);
        same_set = acc_en && (access_set == query_set);
        victim   = (|inv_ext) ? inv_way : pol_way;
    end

    if (POLICY == REPL_LRU) begin : g_lru
        // Age 0 is least recently used; each set's ages stay a permutation of 0..SET_ASSOC-1.
        logic [WW-1:0] age_q   [SET_NUM][SET_ASSOC];
        logic [WW-1:0] upd_row [SET_ASSOC];
        logic [WW-1:0] qry_row [SET_ASSOC];

        always_comb begin
            for (int w = 0; w < SET_ASSOC; w++) begin
                if (WW'(w) == acc_way) begin
                    upd_row[w] = WW'(SET_ASSOC - 1);
                end else if (age_q[access_set][w] > age_q[access_set][acc_way]) begin
                    upd_row[w] = age_q[access_set][w] - WW'(1);
                end else begin
                    upd_row[w] = age_q[access_set][w];
                end
                qry_row[w] = same_set ? upd_row[w] : age_q[query_set][w];
            end
            pol_way = '0;
            for (int w = 0; w < SET_ASSOC; w++) begin
                if (qry_row[w] == '0) pol_way = WW'(w);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SET_NUM; s++) begin
                    for (int w = 0; w < SET_ASSOC; w++) begin
                        age_q[s][w] <= WW'(w);
                    end
                end
            end else if (acc_en) begin
                for (int w = 0; w < SET_ASSOC; w++) begin
                    age_q[access_set][w] <= upd_row[w];
                end
            end
        end
    end else if (POLICY == REPL_FIFO) begin : g_fifo
        logic [WW-1:0] ptr_q [SET_NUM];
        logic [WW-1:0] ptr_nxt;

        always_comb begin
            ptr_nxt = ptr_q[access_set] + WW'(1);
            pol_way = (same_set && access_fill) ? ptr_nxt : ptr_q[query_set];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SET_NUM; s++) begin
                    ptr_q[s] <= '0;
                end
            end else if (acc_en && access_fill) begin
                ptr_q[access_set] <= ptr_nxt;
            end
        end
    end else begin : g_random
        repl_lfsr #(
            .OUT_W(WW)
        ) u_lfsr (
            .clk(clk),
            .rst(rst),
            .rnd(pol_way)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            way_q   <= '0;
        end else begin
            valid_q <= query_valid;
            if (query_valid) way_q <= victim;
        end
    end

    // Gate with rst so a pending result is suppressed during the reset cycle itself.
    assign repl_valid = valid_q & ~rst;
    assign repl_way   = rst ? '0 : way_q;

    logic unused_bits;
    assign unused_bits = ^{acc_idx, inv_idx, acc_way, access_fill, same_set, access_set};

endmodule
